// File: rtl/writeback_stage.sv
// Writeback stage: final pipeline stage that drives the register-file write port.
// Accepts one retiring instruction per cycle, waits for variable-latency load
// responses (with a bounded timeout), aligns and extends load data, and counts
// committed instructions.

module writeback_stage #(
    parameter int LOAD_TIMEOUT = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [4:0]       inRd,
    input  logic [1:0]       inWbSel,
    input  logic [31:0]      inAluResult,
    input  logic [31:0]      inPcPlus4,
    input  logic [2:0]       inLoadFunct3,
    input  logic [1:0]       inAddrLow,
    input  logic             memRespValid,
    input  logic [31:0]      memRespData,
    output logic [31:0]      writeData,
    output logic [4:0]       writeAddr,
    output logic             writeEn,
    output logic             loadPending,
    output logic [4:0]       loadPendingRd,
    output logic [CNT_W-1:0] retiredCount,
    output logic             loadTimeout
);

    // Wait counter runs 0 .. LOAD_TIMEOUT-1; the last value is the timeout cycle.
    localparam int WAIT_W = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LOAD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_ALU  = 2'b01;
    localparam logic [1:0] SEL_LOAD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LOAD = 2'd1,
        ST_COMMIT    = 2'd2
    } state_t;

    state_t             state_r;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [4:0]         ld_rd_r;
    logic [2:0]         ld_funct3_r;
    logic [1:0]         ld_addr_low_r;
    logic [31:0]        write_data_r;
    logic [4:0]         write_addr_r;
    logic               write_en_r;
    logic               load_pending_r;
    logic [4:0]         load_pending_rd_r;
    logic [CNT_W-1:0]   retired_count_r;
    logic               load_timeout_r;

    logic               ready_s;
    logic [31:0]        sel_data_s;
    logic [31:0]        load_data_s;

    // Select the byte/half lane of a raw word and sign- or zero-extend it.
    // Unused funct3 encodings fall back to a full-word load.
    function automatic logic [31:0] format_load(
        input logic [2:0]  funct3,
        input logic [1:0]  lane,
        input logic [31:0] word
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] result;
        case (lane)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        if (lane[1]) begin
            half_v = word[31:16];
        end else begin
            half_v = word[15:0];
        end
        case (funct3)
            3'b000:  result = {{24{byte_v[7]}}, byte_v};
            3'b001:  result = {{16{half_v[15]}}, half_v};
            3'b100:  result = {24'd0, byte_v};
            3'b101:  result = {16'd0, half_v};
            default: result = word;
        endcase
        return result;
    endfunction

    // Upstream handshake and data-path selection for non-load and load commits.
    always_comb begin
        ready_s     = 1'b1;
        sel_data_s  = inAluResult;
        load_data_s = format_load(ld_funct3_r, ld_addr_low_r, memRespData);
        if (state_r == ST_WAIT_LOAD) begin
            ready_s = 1'b0;
        end else begin
            ready_s = 1'b1;
        end
        if (inWbSel == SEL_ALU) begin
            sel_data_s = inAluResult;
        end else begin
            sel_data_s = inPcPlus4;
        end
    end

    // Writeback FSM with registered register-file port, load tracking and counters.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_r           <= ST_IDLE;
            wait_cnt_r        <= '0;
            ld_rd_r           <= 5'd0;
            ld_funct3_r       <= 3'd0;
            ld_addr_low_r     <= 2'd0;
            write_data_r      <= 32'd0;
            write_addr_r      <= 5'd0;
            write_en_r        <= 1'b0;
            load_pending_r    <= 1'b0;
            load_pending_rd_r <= 5'd0;
            retired_count_r   <= '0;
            load_timeout_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_WAIT_LOAD: begin
                    write_en_r <= 1'b0;
                    if (memRespValid) begin
                        // A response always wins, even in the timeout cycle.
                        write_en_r      <= (ld_rd_r != 5'd0);
                        write_addr_r    <= ld_rd_r;
                        write_data_r    <= load_data_s;
                        retired_count_r <= retired_count_r + CNT_ONE;
                        load_pending_r  <= 1'b0;
                        state_r         <= ST_COMMIT;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        // Abandon the load: no write, not counted.
                        load_timeout_r  <= 1'b1;
                        load_pending_r  <= 1'b0;
                        state_r         <= ST_IDLE;
                    end else begin
                        wait_cnt_r      <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                ST_IDLE, ST_COMMIT: begin
                    write_en_r <= 1'b0;
                    if (inValid) begin
                        if (inWbSel == SEL_LOAD) begin
                            ld_rd_r           <= inRd;
                            ld_funct3_r       <= inLoadFunct3;
                            ld_addr_low_r     <= inAddrLow;
                            load_pending_r    <= 1'b1;
                            load_pending_rd_r <= inRd;
                            wait_cnt_r        <= '0;
                            state_r           <= ST_WAIT_LOAD;
                        end else begin
                            write_en_r        <= (inRd != 5'd0) && (inWbSel != SEL_NONE);
                            write_addr_r      <= inRd;
                            if (inWbSel != SEL_NONE) begin
                                write_data_r  <= sel_data_s;
                            end else begin
                                write_data_r  <= write_data_r;
                            end
                            retired_count_r   <= retired_count_r + CNT_ONE;
                            state_r           <= ST_COMMIT;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    write_en_r     <= 1'b0;
                    load_pending_r <= 1'b0;
                    state_r        <= ST_IDLE;
                end
            endcase
        end
    end

    assign inReady       = ready_s;
    assign writeData     = write_data_r;
    assign writeAddr     = write_addr_r;
    assign writeEn       = write_en_r;
    assign loadPending   = load_pending_r;
    assign loadPendingRd = load_pending_rd_r;
    assign retiredCount  = retired_count_r;
    assign loadTimeout   = load_timeout_r;

endmodule
